// File: rtl/wb_cache_control.sv
// Control FSM for an N-way set-associative, write-back, write-allocate cache.
// Uses tree pseudo-LRU replacement, writes back dirty victims, and keeps saturating hit/miss/write-back counters.
module wb_cache_control #(
    parameter int WAYS  = 4,
    parameter int WAY_W = $clog2(WAYS),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    input  logic [WAYS-1:0]  hit_vec,
    input  logic [WAYS-1:0]  valid_vec,
    input  logic [WAYS-1:0]  dirty_vec,
    input  logic [WAYS-2:0]  plru_out,
    output logic [WAY_W-1:0] way_sel,
    output logic [WAYS-1:0]  load_tag,
    output logic [WAYS-1:0]  load_data,
    output logic [WAYS-1:0]  load_valid,
    output logic             valid_in,
    output logic [WAYS-1:0]  load_dirty,
    output logic             dirty_in,
    output logic             load_plru,
    output logic [WAYS-2:0]  plru_in,
    output logic             data_src,
    output logic             pmem_addr_sel,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WRITE_BACK = 2'd1;
    localparam logic [1:0] ALLOCATE   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WAY_W-1:0] victim_q, victim_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic [CNT_W-1:0] miss_count_q, miss_count_d;
    logic [CNT_W-1:0] wb_count_q, wb_count_d;

    logic             req;
    logic             hit_inc, miss_inc, wb_inc;
    logic [WAY_W-1:0] hit_way, victim_sel;

    function automatic logic [WAY_W-1:0] lowest_set(input logic [WAYS-1:0] v);
        logic [WAY_W-1:0] r;
        r = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (v[i]) r = WAY_W'(i);
        end
        return r;
    endfunction

    // Heap-ordered tree: node k lives in bit k-1; a 0 bit points to the lower half.
    function automatic logic [WAY_W-1:0] plru_walk(input logic [WAYS-2:0] tree);
        logic [WAY_W-1:0] v;
        logic             b;
        int               k;
        v = '0;
        k = 1;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            b = tree[k-1];
            v[WAY_W-1-lvl] = b;
            k = 2 * k + int'(b);
        end
        return v;
    endfunction

    function automatic logic [WAYS-2:0] plru_update(input logic [WAYS-2:0] tree,
                                                    input logic [WAY_W-1:0] w);
        logic [WAYS-2:0] r;
        logic            b;
        int              k;
        r = tree;
        k = 1;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            b = w[WAY_W-1-lvl];
            r[k-1] = ~b;
            k = 2 * k + int'(b);
        end
        return r;
    endfunction

    function automatic logic [WAYS-1:0] way_onehot(input logic [WAY_W-1:0] w);
        return {{(WAYS-1){1'b0}}, 1'b1} << w;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign hit_way    = lowest_set(hit_vec);
    assign victim_sel = (&valid_vec) ? plru_walk(plru_out) : lowest_set(~valid_vec);
    // Gating with rst keeps every output quiet while reset is held, even with a request pending.
    assign req        = (mem_read | mem_write) & ~rst;

    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;
        wb_inc        = 1'b0;
        mem_resp      = 1'b0;
        way_sel       = '0;
        load_tag      = '0;
        load_data     = '0;
        load_valid    = '0;
        valid_in      = 1'b0;
        load_dirty    = '0;
        dirty_in      = 1'b0;
        load_plru     = 1'b0;
        plru_in       = '0;
        data_src      = 1'b0;
        pmem_addr_sel = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req && (|hit_vec)) begin
                    mem_resp  = 1'b1;
                    hit_inc   = 1'b1;
                    way_sel   = hit_way;
                    load_plru = 1'b1;
                    plru_in   = plru_update(plru_out, hit_way);
                    if (mem_write) begin
                        load_data  = way_onehot(hit_way);
                        load_dirty = way_onehot(hit_way);
                        dirty_in   = 1'b1;
                    end
                end else if (req) begin
                    miss_inc = 1'b1;
                    victim_d = victim_sel;
                    if (valid_vec[victim_sel] && dirty_vec[victim_sel]) begin
                        state_d = WRITE_BACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end
            WRITE_BACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                way_sel       = victim_q;
                if (pmem_resp) begin
                    wb_inc  = 1'b1;
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                way_sel   = victim_q;
                if (pmem_resp) begin
                    data_src   = 1'b1;
                    load_data  = way_onehot(victim_q);
                    load_tag   = way_onehot(victim_q);
                    load_valid = way_onehot(victim_q);
                    valid_in   = 1'b1;
                    load_dirty = way_onehot(victim_q);
                    dirty_in   = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hit_count_d  = hit_inc  ? sat_inc(hit_count_q)  : hit_count_q;
        miss_count_d = miss_inc ? sat_inc(miss_count_q) : miss_count_q;
        wb_count_d   = wb_inc   ? sat_inc(wb_count_q)   : wb_count_q;
        if (cnt_clear) begin
            hit_count_d  = '0;
            miss_count_d = '0;
            wb_count_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            victim_q     <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            wb_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            wb_count_q   <= wb_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
    assign wb_count   = wb_count_q;

endmodule

// File: tb/tb_wb_cache_control.sv
// Directed bench for wb_cache_control: a WAYS=4/CNT_W=16 instance for the FSM scenarios
// and a CNT_W=4 instance sharing the same stimulus for counter saturation.
module tb_wb_cache_control;

    logic       clk;
    logic       rst;
    logic       mem_read, mem_write;
    logic [3:0] hit_vec, valid_vec, dirty_vec;
    logic [2:0] plru_out;
    logic       pmem_resp;
    logic       cnt_clear;

    logic        mem_resp, valid_in, dirty_in, load_plru, data_src, pmem_addr_sel, pmem_read, pmem_write;
    logic [1:0]  way_sel;
    logic [3:0]  load_tag, load_data, load_valid, load_dirty;
    logic [2:0]  plru_in;
    logic [15:0] hit_count, miss_count, wb_count;

    logic        s_mem_resp, s_valid_in, s_dirty_in, s_load_plru, s_data_src, s_pmem_addr_sel, s_pmem_read, s_pmem_write;
    logic [1:0]  s_way_sel;
    logic [3:0]  s_load_tag, s_load_data, s_load_valid, s_load_dirty;
    logic [2:0]  s_plru_in;
    logic [3:0]  s_hit_count, s_miss_count, s_wb_count;

    int checks   = 0;
    int failures = 0;

    wb_cache_control #(.WAYS(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .plru_out(plru_out),
        .way_sel(way_sel), .load_tag(load_tag), .load_data(load_data), .load_valid(load_valid),
        .valid_in(valid_in), .load_dirty(load_dirty), .dirty_in(dirty_in), .load_plru(load_plru),
        .plru_in(plru_in), .data_src(data_src), .pmem_addr_sel(pmem_addr_sel),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .cnt_clear(cnt_clear), .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    wb_cache_control #(.WAYS(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(s_mem_resp),
        .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .plru_out(plru_out),
        .way_sel(s_way_sel), .load_tag(s_load_tag), .load_data(s_load_data), .load_valid(s_load_valid),
        .valid_in(s_valid_in), .load_dirty(s_load_dirty), .dirty_in(s_dirty_in), .load_plru(s_load_plru),
        .plru_in(s_plru_in), .data_src(s_data_src), .pmem_addr_sel(s_pmem_addr_sel),
        .pmem_read(s_pmem_read), .pmem_write(s_pmem_write), .pmem_resp(pmem_resp),
        .cnt_clear(cnt_clear), .hit_count(s_hit_count), .miss_count(s_miss_count), .wb_count(s_wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are checked 2 units later, mid-cycle.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [3:0] hit,
                                 input logic [3:0] valid, input logic [3:0] dirty,
                                 input logic [2:0] plru, input logic presp);
        mem_read  = rd;
        mem_write = wr;
        hit_vec   = hit;
        valid_vec = valid;
        dirty_vec = dirty;
        plru_out  = plru;
        pmem_resp = presp;
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one read miss from the IDLE miss cycle through the allocate fill; the caller then drives the hit cycle.
    task automatic missSeq(input string tag, input logic [3:0] valid, input logic [3:0] dirty,
                           input logic [2:0] plru, input logic [1:0] exp_victim, input logic exp_wb);
        logic [3:0] exp_onehot;
        exp_onehot = 4'b0001 << exp_victim;
        applyStimulus(1'b1, 1'b0, 4'b0000, valid, dirty, plru, 1'b0);
        checkOutput({tag, "_idle_resp"}, mem_resp, 1'b0);
        checkOutput({tag, "_idle_pread"}, pmem_read, 1'b0);
        tick();
        if (exp_wb) begin
            applyStimulus(1'b1, 1'b0, 4'b0000, valid, dirty, plru, 1'b0);
            checkOutput({tag, "_wb_pwrite"}, pmem_write, 1'b1);
            checkOutput({tag, "_wb_asel"}, pmem_addr_sel, 1'b1);
            checkOutput({tag, "_wb_way"}, way_sel, exp_victim);
            checkOutput({tag, "_wb_pread"}, pmem_read, 1'b0);
            tick();
            applyStimulus(1'b1, 1'b0, 4'b0000, valid, dirty, plru, 1'b1);
            checkOutput({tag, "_wb_pwrite_resp"}, pmem_write, 1'b1);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 4'b0000, valid, dirty, plru, 1'b0);
        checkOutput({tag, "_al_pread"}, pmem_read, 1'b1);
        checkOutput({tag, "_al_pwrite"}, pmem_write, 1'b0);
        checkOutput({tag, "_al_asel"}, pmem_addr_sel, 1'b0);
        checkOutput({tag, "_al_nofill"}, load_data, 4'b0000);
        tick();
        applyStimulus(1'b1, 1'b0, 4'b0000, valid, dirty, plru, 1'b1);
        checkOutput({tag, "_fill_data"}, load_data, exp_onehot);
        checkOutput({tag, "_fill_tag"}, load_tag, exp_onehot);
        checkOutput({tag, "_fill_valid"}, {load_valid, valid_in}, {exp_onehot, 1'b1});
        checkOutput({tag, "_fill_dirty"}, {load_dirty, dirty_in}, {exp_onehot, 1'b0});
        checkOutput({tag, "_fill_src"}, data_src, 1'b1);
        checkOutput({tag, "_fill_resp"}, mem_resp, 1'b0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        cnt_clear = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0000, 3'b000, 1'b0);
        checkOutput("rst_resp", mem_resp, 1'b0);
        checkOutput("rst_plru", load_plru, 1'b0);
        checkOutput("rst_pmem", {pmem_read, pmem_write}, 2'b00);
        checkOutput("rst_counts", {hit_count, miss_count, wb_count}, 48'h0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 3'b000, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("idle_quiet", {mem_resp, pmem_read, pmem_write, load_data}, 7'h0);

        // T1: cold set, allocate into way0
        missSeq("t1", 4'b0000, 4'b0000, 3'b000, 2'd0, 1'b0);
        checkOutput("t1_miss", miss_count, 16'd1);
        applyStimulus(1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0000, 3'b000, 1'b0);
        checkOutput("t1_resp", mem_resp, 1'b1);
        checkOutput("t1_plru_in", {load_plru, plru_in}, {1'b1, 3'b011});
        checkOutput("t1_way", way_sel, 2'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0001, 4'b0000, 3'b011, 1'b0);
        checkOutput("t1_hit", hit_count, 16'd1);

        // T2: fill ways 1..3 through invalid-way selection, then PLRU picks way0
        missSeq("t2w1", 4'b0001, 4'b0000, 3'b011, 2'd1, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'b0010, 4'b0011, 4'b0000, 3'b011, 1'b0);
        checkOutput("t2w1_plru_in", plru_in, 3'b001);
        tick();
        missSeq("t2w2", 4'b0011, 4'b0000, 3'b001, 2'd2, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'b0100, 4'b0111, 4'b0000, 3'b001, 1'b0);
        checkOutput("t2w2_plru_in", plru_in, 3'b100);
        tick();
        missSeq("t2w3", 4'b0111, 4'b0000, 3'b100, 2'd3, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'b1000, 4'b1111, 4'b0000, 3'b100, 1'b0);
        checkOutput("t2w3_plru_in", plru_in, 3'b000);
        tick();
        missSeq("t2evict", 4'b1111, 4'b0000, 3'b000, 2'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'b0001, 4'b1111, 4'b0000, 3'b000, 1'b0);
        checkOutput("t2evict_plru_in", plru_in, 3'b011);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 3'b011, 1'b0);
        checkOutput("t2_counts", {hit_count, miss_count, wb_count}, {16'd5, 16'd5, 16'd0});

        // T3: write hit way2 then evict it as a dirty victim
        applyStimulus(1'b0, 1'b1, 4'b0100, 4'b1111, 4'b0000, 3'b011, 1'b0);
        checkOutput("t3_wresp", mem_resp, 1'b1);
        checkOutput("t3_wdata", {load_data, data_src}, {4'b0100, 1'b0});
        checkOutput("t3_wdirty", {load_dirty, dirty_in}, {4'b0100, 1'b1});
        checkOutput("t3_wplru", {way_sel, plru_in}, {2'd2, 3'b110});
        tick();
        missSeq("t3evict", 4'b1111, 4'b0100, 3'b001, 2'd2, 1'b1);
        applyStimulus(1'b1, 1'b0, 4'b0100, 4'b1111, 4'b0000, 3'b001, 1'b0);
        checkOutput("t3_hit_resp", {mem_resp, plru_in}, {1'b1, 3'b100});
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 3'b100, 1'b0);
        checkOutput("t3_counts", {hit_count, miss_count, wb_count}, {16'd7, 16'd6, 16'd1});

        // T4: reset during write-back
        applyStimulus(1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0001, 3'b000, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0001, 3'b000, 1'b0);
        checkOutput("t4_pwrite_before", pmem_write, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("t4_pwrite_drop", {pmem_write, pmem_read, pmem_addr_sel}, 3'b000);
        checkOutput("t4_counts", {hit_count, miss_count, wb_count}, 48'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0001, 3'b000, 1'b0);
        rst = 1'b0;
        tick();
        applyStimulus(1'b1, 1'b0, 4'b0010, 4'b1111, 4'b0001, 3'b000, 1'b0);
        checkOutput("t4_idle_hit", {mem_resp, pmem_write}, 2'b10);
        tick();

        // T5: request withdrawn during allocate
        applyStimulus(1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0000, 3'b000, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 3'b000, 1'b0);
        checkOutput("t5_pread_held", pmem_read, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 3'b000, 1'b1);
        checkOutput("t5_fill", {load_valid, load_tag, mem_resp}, {4'b0001, 4'b0001, 1'b0});
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 3'b000, 1'b0);
        checkOutput("t5_idle", {pmem_read, mem_resp}, 2'b00);
        applyStimulus(1'b1, 1'b0, 4'b0001, 4'b1111, 4'b0000, 3'b000, 1'b0);
        checkOutput("t5_idle_hit", mem_resp, 1'b1);
        tick();

        // T6: 4-bit counter saturation and clear priority
        cnt_clear = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 3'b000, 1'b0);
        tick();
        cnt_clear = 1'b0;
        checkOutput("t6_cleared", s_hit_count, 4'h0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, 4'b0001, 4'b1111, 4'b0000, 3'b000, 1'b0);
            tick();
            if (i == 13) checkOutput("t6_count14", s_hit_count, 4'hE);
        end
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 3'b000, 1'b0);
        checkOutput("t6_saturated", s_hit_count, 4'hF);
        checkOutput("t6_wide_count", hit_count, 16'd20);
        cnt_clear = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'b0001, 4'b1111, 4'b0000, 3'b000, 1'b0);
        checkOutput("t6_clear_hit_resp", s_mem_resp, 1'b1);
        tick();
        cnt_clear = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 3'b000, 1'b0);
        checkOutput("t6_clear_wins", {s_hit_count, hit_count}, {4'h0, 16'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
